irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt controller that consumes the active-low `irq_` outputs of the bus peripherals (timer and others) and presents a single prioritised request to the CPU. It sits directly downstream of the timer's interrupt output and on the same slave bus as the timer, with the same `cs_`/`as_`/`rw`/`rdy_` handshake. Pending, mask and status registers are software-visible. A three-state service FSM enforces one interrupt in service at a time until software writes end-of-interrupt (EOI).

## Interface
- `NUM_IRQ`, default 8: number of interrupt sources, 1..32.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cs_`  in  1  chip select, active low.
- `as_`  in  1  address strobe, active low.
- `rw`  in  1  1 = read, 0 = write.
- `addr`  in  2  register select.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  read data.
- `rdy_`  out  1  bus ready, active low.
- `irq_`  in  NUM_IRQ  source requests, active low, synchronous to `clk`.
- `int_req`  out  1  interrupt request to CPU, active high.
- `int_id`  out  5  index of the requested source.
- `int_ack`  in  1  one-cycle CPU acknowledge.

## Operation
- Registers:
  - addr 0 PEND: read returns pending bits. A write of 1 clears that bit (W1C).
  - addr 1 MASK: read/write. A 1 enables the source.
  - addr 2 STAT: read returns {25'b0, state[1:0], id[4:0]}. Any write is an EOI.
  - addr 3 TRIG: see Configuration.
  - Bits at or above `NUM_IRQ` read 0 and ignore writes.
- Pending set condition: source asserted (`irq_[i]` = 0) for level sources, or a high-to-low transition of `irq_[i]` for edge sources.
- Same-cycle set and clear of a pending bit (W1C or ack): set wins.
- Priority: the lowest index among `pend & mask`.
- FSM states:
  - IDLE (`int_req` = 0): if `pend & mask` ≠ 0, latch the winner into `int_id` and go to REQ.
  - REQ (`int_req` = 1, `int_id` held stable): on `int_ack`, clear `pend[int_id]` and go to SVC. If `pend[int_id] & mask[int_id]` drops before ack (W1C or mask write), withdraw to IDLE.
  - SVC (`int_req` = 0): a higher-priority arrival does not preempt. An EOI write goes to IDLE.
- `int_ack` in IDLE or SVC is ignored.
- Because pending is re-set each cycle while a level source stays asserted, a level source still asserted after EOI re-requests.
- Reset values: `rd_data` = 0, `rdy_` = 1, `int_req` = 0, `int_id` = 0, PEND = 0, MASK = 0, TRIG = 0, state = IDLE, edge history = all 1.
- Reset mid-operation (any state) returns the block to IDLE and drops `int_req` immediately (asynchronously).

## Timing
- Bus access: `cs_` = `as_` = 0 sampled at edge N → `rdy_` = 0 and `rd_data` valid after edge N, for one cycle.
- `rdy_` returns to 1 after the next edge unless another access is sampled.
- `rd_data` is 0 whenever no read is sampled.
- Writes take effect at the sampling edge N.
- Source latency: `irq_` low sampled at edge N → PEND bit set after N; FSM enters REQ at N+1, so `int_req` = 1 after N+1.
- `int_ack` sampled at edge M → `int_req` = 0 and PEND bit cleared after M.
- EOI write at edge K → IDLE after K. If another request is pending, REQ after K+1.
- Back-to-back bus accesses are allowed every cycle.

## Configuration
- Macro `IRQ_CTRL_EDGE_EN`.
- Defined: TRIG register at addr 3 is read/write, one bit per source, 1 = edge-triggered. Edge history is registered per source.
- Undefined: every source is level-triggered. TRIG reads 0, writes are ignored, and no edge-history flops are built.

## Structure
- Shared package/header holds:
  - `IRQ_ADDR_PEND`, `IRQ_ADDR_MASK`, `IRQ_ADDR_STAT`, `IRQ_ADDR_TRIG`
  - state encodings `IRQ_ST_IDLE` = 0, `IRQ_ST_REQ` = 1, `IRQ_ST_SVC` = 2
  - `IRQ_MAX` = 32
  - `READ`/`WRITE` and active-low enable constants, shared with the timer.
- Sub-module `irq_prio_enc`: a combinational lowest-index encoder that takes a `NUM_IRQ`-wide vector and outputs a valid flag and a 5-bit index.

## Test plan
- Reset, then read all four registers → PEND = 0, MASK = 0, STAT = 0, TRIG = 0; `int_req` = 0, `rdy_` = 1.
- MASK = 0x05; drive `irq_[2]` low at edge N → `int_req` = 1 after N+1 with `int_id` = 2. Pulse `int_ack` → `int_req` = 0 and STAT reads state SVC (2).
- Assert sources 2 and 0 in the same cycle with MASK = 0xFF → `int_id` = 0. After ack and EOI, source 0 is released and source 2 is still asserted → next request is `int_id` = 2.
- In REQ for source 3, write MASK = 0 → `int_req` = 0 and state IDLE with no ack. Restore MASK = 0x08 → request re-asserted.
- With `IRQ_CTRL_EDGE_EN`: TRIG = 0x01; hold `irq_[0]` low → exactly one PEND set. After ack and EOI, no new request until `irq_` goes 1 then 0.
- Assert `reset` while in SVC with PEND = 0x0F → all registers cleared and `int_req` = 0 immediately. After release, the FSM is in IDLE.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for irq_ctrl: register map, service-FSM encodings, bus polarity
// constants shared with the timer, and the STAT register layout.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_ADDR_PEND = 2'd0;
  localparam logic [1:0] IRQ_ADDR_MASK = 2'd1;
  localparam logic [1:0] IRQ_ADDR_STAT = 2'd2;
  localparam logic [1:0] IRQ_ADDR_TRIG = 2'd3;

  localparam logic [1:0] IRQ_ST_IDLE = 2'd0;
  localparam logic [1:0] IRQ_ST_REQ  = 2'd1;
  localparam logic [1:0] IRQ_ST_SVC  = 2'd2;

  localparam int IRQ_MAX = 32;

  localparam logic READ       = 1'b1;
  localparam logic WRITE      = 1'b0;
  localparam logic ASSERTED_N = 1'b0;
  localparam logic NEGATED_N  = 1'b1;

  typedef struct packed {
    logic [24:0] rsvd;
    logic [1:0]  state;
    logic [4:0]  id;
  } irq_stat_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder: valid when any request bit is set,
// idx is the position of the lowest set bit.
module irq_prio_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [4:0]         idx
);

  always_comb begin
    valid = |req;
    idx   = 5'd0;
    // Scan downwards so the lowest set bit is written last and wins.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller with PEND/MASK/STAT/TRIG registers and an
// IDLE/REQ/SVC service FSM (state visible in STAT). Edge triggering: IRQ_CTRL_EDGE_EN.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs_,
  input  logic               as_,
  input  logic               rw,
  input  logic [1:0]         addr,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               rdy_,
  input  logic [NUM_IRQ-1:0] irq_,
  output logic               int_req,
  output logic [4:0]         int_id,
  input  logic               int_ack
);

  // Bus handshake: an access is cs_ = as_ = 0 sampled at a clock edge; the block
  // answers with rdy_ = 0 (and rd_data for reads) for exactly the following cycle.
  // Writes take effect at that same sampling edge; accesses may come every cycle.
  logic access, wr_en, rd_en, eoi, ack_take, keep_req;
  logic win_valid;
  logic [4:0] win_idx, id_nxt;
  logic [1:0] state, state_nxt;
  logic [NUM_IRQ-1:0] pend, pend_nxt, mask, mask_nxt, trig, set_vec, clr_vec, w1c_vec;
  logic [IRQ_MAX-1:0] pend_ext, mask_ext;
  logic [31:0] rd_mux;
  irq_stat_t stat;
  logic unused_wr;

  assign access   = (cs_ == ASSERTED_N) && (as_ == ASSERTED_N);
  assign wr_en    = access && (rw == WRITE);
  assign rd_en    = access && (rw == READ);
  assign eoi      = wr_en && (addr == IRQ_ADDR_STAT);
  assign ack_take = (state == IRQ_ST_REQ) && int_ack;
  assign unused_wr = ^wr_data;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] irq_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig     <= '0;
      irq_hist <= '1;
    end else begin
      irq_hist <= irq_;
      if (wr_en && (addr == IRQ_ADDR_TRIG)) trig <= wr_data[NUM_IRQ-1:0];
    end
  end

  assign set_vec = (~irq_ & ~trig) | (irq_hist & ~irq_ & trig);
`else
  assign trig    = '0;
  assign set_vec = ~irq_;
`endif

  assign w1c_vec = (wr_en && (addr == IRQ_ADDR_PEND)) ? wr_data[NUM_IRQ-1:0] : '0;

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_vec[i] = w1c_vec[i] | (ack_take && (int_id == 5'(i)));
    end
  end

  // A new assertion in the same cycle as a clear keeps the bit pending.
  assign pend_nxt = (pend & ~clr_vec) | set_vec;
  assign mask_nxt = (wr_en && (addr == IRQ_ADDR_MASK)) ? wr_data[NUM_IRQ-1:0] : mask;

  assign pend_ext = 32'(pend_nxt);
  assign mask_ext = 32'(mask_nxt);
  assign keep_req = pend_ext[int_id] & mask_ext[int_id];

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req   (pend & mask),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    state_nxt = state;
    id_nxt    = int_id;
    case (state)
      IRQ_ST_IDLE: begin
        if (win_valid) begin
          state_nxt = IRQ_ST_REQ;
          id_nxt    = win_idx;
        end
      end
      IRQ_ST_REQ: begin
        // Withdraw when software clears or masks the requested source before ack.
        if (int_ack)        state_nxt = IRQ_ST_SVC;
        else if (!keep_req) state_nxt = IRQ_ST_IDLE;
      end
      IRQ_ST_SVC: begin
        if (eoi) state_nxt = IRQ_ST_IDLE;
      end
      default: state_nxt = IRQ_ST_IDLE;
    endcase
  end

  always_comb begin
    stat       = '0;
    stat.state = state;
    stat.id    = int_id;
    case (addr)
      IRQ_ADDR_PEND: rd_mux = 32'(pend);
      IRQ_ADDR_MASK: rd_mux = 32'(mask);
      IRQ_ADDR_STAT: rd_mux = stat;
      IRQ_ADDR_TRIG: rd_mux = 32'(trig);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend    <= '0;
      mask    <= '0;
      state   <= IRQ_ST_IDLE;
      int_id  <= 5'd0;
      rd_data <= '0;
      rdy_    <= NEGATED_N;
    end else begin
      pend    <= pend_nxt;
      mask    <= mask_nxt;
      state   <= state_nxt;
      int_id  <= id_nxt;
      rd_data <= rd_en ? rd_mux : '0;
      rdy_    <= access ? ASSERTED_N : NEGATED_N;
    end
  end

  // Decoded straight from state so an asynchronous reset drops it at once.
  assign int_req = (state == IRQ_ST_REQ);

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed register/FSM scenarios with literal expectations plus
// a randomized phase, all outputs compared every cycle against a behavioural model.
module tb_irq_ctrl;

  localparam int NUM_IRQ = 8;
  localparam logic [31:0] VMASK = 32'h0000_00FF;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic cs_, as_, rw, int_ack;
  logic [1:0] addr;
  logic [31:0] wr_data, rd_data;
  logic rdy_, int_req;
  logic [4:0] int_id;
  logic [NUM_IRQ-1:0] irq_;

  always #5 clk = ~clk;

  irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .irq_    (irq_),
    .int_req (int_req),
    .int_id  (int_id),
    .int_ack (int_ack)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [31:0] exp_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State numbering: 0 = idle, 1 = request outstanding, 2 = in service.
  logic [31:0] m_pend, m_mask, m_trig, m_hist, m_rd;
  int          m_state;
  logic [4:0]  m_id;
  logic        m_rdy;

  function automatic logic [4:0] lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return 5'(i);
    return 5'd0;
  endfunction

  function automatic logic [31:0] reg_view(input logic [1:0] a);
    case (a)
      2'd0:    return m_pend;
      2'd1:    return m_mask;
      2'd2:    return {25'b0, 2'(m_state), m_id};
      default: return m_trig;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = 0; m_mask = 0; m_trig = 0; m_hist = '1;
      m_state = 0; m_id = 0; m_rd = 0; m_rdy = 1'b1;
    end else begin : step
      logic [31:0] low, setb, clrb, np, nm, nt;
      bit acc, wr, rd;
      acc  = !cs_ && !as_;
      wr   = acc && !rw;
      rd   = acc && rw;
      low  = {24'b0, ~irq_};
      m_rd  = rd ? reg_view(addr) : 32'd0;
      m_rdy = !acc;
      setb = 0;
      for (int i = 0; i < NUM_IRQ; i++) setb[i] = m_trig[i] ? (m_hist[i] && low[i]) : low[i];
      clrb = (wr && addr == 2'd0) ? (wr_data & VMASK) : 32'd0;
      if (m_state == 1 && int_ack) clrb[m_id] = 1'b1;
      np = (m_pend & ~clrb) | setb;
      nm = (wr && addr == 2'd1) ? (wr_data & VMASK) : m_mask;
      nt = m_trig;
`ifdef IRQ_CTRL_EDGE_EN
      if (wr && addr == 2'd3) nt = wr_data & VMASK;
`endif
      case (m_state)
        0: if ((m_pend & m_mask) != 0) begin m_id = lowest(m_pend & m_mask); m_state = 1; end
        1: if (int_ack) m_state = 2; else if (!(np[m_id] && nm[m_id])) m_state = 0;
        2: if (wr && addr == 2'd2) m_state = 0;
        default: m_state = 0;
      endcase
      m_pend = np; m_mask = nm; m_trig = nt;
      m_hist = {24'hFF_FFFF, irq_};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("rd_data", rd_data, m_rd);
      cmp("rdy_", {31'b0, rdy_}, {31'b0, m_rdy});
      cmp("int_req", {31'b0, int_req}, {31'b0, (m_state == 1)});
      cmp("int_id", {27'b0, int_id}, {27'b0, m_id});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
  endtask

  task automatic read_expect(input string name, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] d;
    exp_q.push_back(e);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
    @(negedge clk);
    d = rd_data;
    cs_ = 1'b1; as_ = 1'b1;
    cmp(name, d, exp_q.pop_front());
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    cycles(1);
    int_ack = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic req, input logic [4:0] id);
    cmp({name, "_req"}, {31'b0, int_req}, {31'b0, req});
    if (req) cmp({name, "_id"}, {27'b0, int_id}, {27'b0, id});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = 2'd0; wr_data = 0;
    irq_ = '1; int_ack = 1'b0;
    cycles(3);
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    cmp("rst_int_req", {31'b0, int_req}, 32'd0);
    cmp("rst_rdy_", {31'b0, rdy_}, 32'd1);
    read_expect("rst_pend", 2'd0, 32'h0);
    read_expect("rst_mask", 2'd1, 32'h0);
    read_expect("rst_stat", 2'd2, 32'h0);
    read_expect("rst_trig", 2'd3, 32'h0);

    // Single source, latency and service state
    bus_write(2'd1, 32'h05);
    irq_[2] = 1'b0;
    cycles(1);
    chk_out("src2_n", 1'b0, 5'd0);
    cycles(1);
    chk_out("src2_n1", 1'b1, 5'd2);
    ack_pulse();
    chk_out("src2_ack", 1'b0, 5'd0);
    read_expect("src2_stat_svc", 2'd2, 32'h42);
    irq_[2] = 1'b1;
    bus_write(2'd0, 32'h04);
    read_expect("src2_pend_w1c", 2'd0, 32'h0);
    bus_write(2'd2, 32'h0);
    cycles(2);
    chk_out("src2_eoi", 1'b0, 5'd0);
    read_expect("src2_stat_idle", 2'd2, 32'h02);

    // Priority between simultaneous sources, then re-request after EOI
    bus_write(2'd1, 32'hFF);
    irq_[0] = 1'b0; irq_[2] = 1'b0;
    cycles(2);
    chk_out("prio_first", 1'b1, 5'd0);
    irq_[0] = 1'b1;
    cycles(1);
    ack_pulse();
    chk_out("prio_ack", 1'b0, 5'd0);
    read_expect("prio_pend", 2'd0, 32'h04);
    bus_write(2'd2, 32'h0);
    chk_out("prio_eoi_k", 1'b0, 5'd0);
    cycles(1);
    chk_out("prio_second", 1'b1, 5'd2);
    irq_[2] = 1'b1;
    cycles(1);
    ack_pulse();
    bus_write(2'd2, 32'h0);
    bus_write(2'd1, 32'h0);

    // Withdraw by mask write, then re-request
    bus_write(2'd1, 32'h08);
    irq_[3] = 1'b0;
    cycles(2);
    chk_out("wd_req", 1'b1, 5'd3);
    bus_write(2'd1, 32'h0);
    chk_out("wd_drop", 1'b0, 5'd0);
    read_expect("wd_stat", 2'd2, 32'h03);
    bus_write(2'd1, 32'h08);
    cycles(1);
    chk_out("wd_restore", 1'b1, 5'd3);
    irq_[3] = 1'b1;
    cycles(1);
    ack_pulse();
    bus_write(2'd2, 32'h0);
    bus_write(2'd1, 32'h0);

`ifdef IRQ_CTRL_EDGE_EN
    // Edge-triggered source: one set per falling edge
    bus_write(2'd3, 32'h01);
    read_expect("edge_trig", 2'd3, 32'h01);
    bus_write(2'd1, 32'h01);
    irq_[0] = 1'b0;
    cycles(2);
    chk_out("edge_req", 1'b1, 5'd0);
    ack_pulse();
    read_expect("edge_pend_once", 2'd0, 32'h0);
    bus_write(2'd2, 32'h0);
    cycles(3);
    chk_out("edge_held", 1'b0, 5'd0);
    irq_[0] = 1'b1;
    cycles(1);
    irq_[0] = 1'b0;
    cycles(2);
    chk_out("edge_again", 1'b1, 5'd0);
    irq_[0] = 1'b1;
    ack_pulse();
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'h0);
    bus_write(2'd1, 32'h0);
`else
    bus_write(2'd3, 32'hFF);
    read_expect("trig_ignored", 2'd3, 32'h0);
`endif

    // Asynchronous reset while in service
    bus_write(2'd1, 32'h0F);
    irq_[3:0] = 4'h0;
    cycles(2);
    chk_out("rst_svc_req", 1'b1, 5'd0);
    ack_pulse();
    read_expect("rst_svc_stat", 2'd2, 32'h40);
    read_expect("rst_svc_pend", 2'd0, 32'h0F);
    #2 reset = 1'b1;
    #1 cmp("rst_async_int_req", {31'b0, int_req}, 32'd0);
    irq_ = '1;
    cycles(2);
    reset = 1'b0;
    read_expect("rst2_pend", 2'd0, 32'h0);
    read_expect("rst2_mask", 2'd1, 32'h0);
    read_expect("rst2_stat", 2'd2, 32'h0);
    read_expect("rst2_trig", 2'd3, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        #3 reset = 1'b1;
        #4 reset = 1'b0;
      end else begin
        for (int i = 0; i < NUM_IRQ; i++) if ($urandom_range(7) == 0) irq_[i] = ~irq_[i];
        int_ack = ($urandom_range(3) == 0);
        if ($urandom_range(2) == 0) begin
          cs_ = 1'b0; as_ = 1'b0;
          rw = 1'($urandom_range(1));
          addr = 2'($urandom_range(3));
          wr_data = $urandom;
        end else begin
          cs_ = 1'b1;
          as_ = 1'($urandom_range(1));
          rw = 1'($urandom_range(1));
        end
      end
    end
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1; int_ack = 1'b0; irq_ = '1;
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
